// File: rtl/dcache_pkg.sv
// Shared types and address-split helpers for the data cache controller.
// Optional statistics counters are enabled by defining DCACHE_STATS_EN.
package dcache_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPARE,
        S_WRITEBACK,
        S_ALLOCATE
    } state_e;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int OFF_LSB = 1;

    function automatic int off_bits(input int words);
        return $clog2(words);
    endfunction

    function automatic int idx_bits(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int idx_lsb(input int words);
        return OFF_LSB + off_bits(words);
    endfunction

    function automatic int tag_lsb(input int lines, input int words);
        return idx_lsb(words) + idx_bits(lines);
    endfunction

    function automatic int tag_bits(input int lines, input int words);
        return ADDR_W - tag_lsb(lines, words);
    endfunction

endpackage

// File: rtl/dcache_line_store.sv
// Tag/valid/dirty and data storage for a direct-mapped cache.
// Reads are combinational; writes touch one word or one tag per cycle.
module dcache_line_store
    import dcache_pkg::*;
#(
    parameter int LINES = 32,
    parameter int WORDS = 4,
    localparam int IDX_W = idx_bits(LINES),
    localparam int OFF_W = off_bits(WORDS),
    localparam int TAG_W = tag_bits(LINES, WORDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] i_idx,
    input  logic [OFF_W-1:0] i_off,
    output logic [TAG_W-1:0] o_tag,
    output logic             o_valid,
    output logic             o_dirty,
    output logic [15:0]      o_rdata,
    input  logic             i_we,
    input  logic [15:0]      i_wdata,
    input  logic             i_set_dirty,
    input  logic             i_install,
    input  logic [TAG_W-1:0] i_tag
);

    logic [15:0]      r_data [LINES*WORDS];
    logic [TAG_W-1:0] r_tag  [LINES];
    logic [LINES-1:0] r_valid;
    logic [LINES-1:0] r_dirty;

    assign o_tag   = r_tag[i_idx];
    assign o_valid = r_valid[i_idx];
    assign o_dirty = r_dirty[i_idx];
    assign o_rdata = r_data[{i_idx, i_off}];

    // Word and tag arrays: no reset, contents qualified by valid
    always_ff @(posedge clk) begin
        if (i_we)
            r_data[{i_idx, i_off}] <= i_wdata;
        if (i_install)
            r_tag[i_idx] <= i_tag;
    end

    // Valid/dirty bits: cleared on reset, installed clean after refill
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_install) begin
            r_valid[i_idx] <= 1'b1;
            r_dirty[i_idx] <= 1'b0;
        end else if (i_set_dirty) begin
            r_dirty[i_idx] <= 1'b1;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache controller.
// Define DCACHE_STATS_EN to build saturating hit/miss counters.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int LINES = 32,
    parameter int WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    input  logic        rd,
    input  logic        wr,
    output logic [15:0] data_out,
    output logic        done,
    output logic        stall,
    output logic        cache_hit,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic [15:0] hit_cnt,
    output logic [15:0] miss_cnt
);

    localparam int IDX_W = idx_bits(LINES);
    localparam int OFF_W = off_bits(WORDS);
    localparam int TAG_W = tag_bits(LINES, WORDS);
    localparam int IDX_L = idx_lsb(WORDS);
    localparam int TAG_L = tag_lsb(LINES, WORDS);
    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS - 1);

    state_e           r_state;
    logic [15:1]      r_addr;
    logic [15:0]      r_wdata;
    logic             r_wr;
    logic             r_missed;
    logic [OFF_W-1:0] r_cnt;
    logic [15:0]      r_dout;

    logic [OFF_W-1:0] w_r_off;
    logic [IDX_W-1:0] w_r_idx;
    logic [TAG_W-1:0] w_r_tag;
    logic [OFF_W-1:0] w_off;
    logic [TAG_W-1:0] w_line_tag;
    logic             w_line_valid;
    logic             w_line_dirty;
    logic [15:0]      w_line_rdata;
    logic             w_idle;
    logic             w_cmp;
    logic             w_wb;
    logic             w_alloc;
    logic             w_accept;
    logic             w_illegal;
    logic             w_hit;
    logic             w_miss;
    logic             w_last;
    logic             w_we;
    logic [15:0]      w_wdata;
    logic             w_set_dirty;
    logic             w_install;

    assign w_r_off = r_addr[IDX_L-1:OFF_LSB];
    assign w_r_idx = r_addr[TAG_L-1:IDX_L];
    assign w_r_tag = r_addr[15:TAG_L];

    assign w_idle  = (r_state == S_IDLE);
    assign w_cmp   = (r_state == S_COMPARE);
    assign w_wb    = (r_state == S_WRITEBACK);
    assign w_alloc = (r_state == S_ALLOCATE);

    assign w_accept  = rst & w_idle & (rd ^ wr) & ~addr[0];
    assign w_illegal = rst & w_idle & ((rd & wr) | ((rd | wr) & addr[0]));

    assign w_off  = w_cmp ? w_r_off : r_cnt;
    assign w_hit  = w_cmp & w_line_valid & (w_line_tag == w_r_tag);
    assign w_miss = w_cmp & ~w_hit;
    assign w_last = (r_cnt == LAST_WORD);

    assign w_set_dirty = w_hit & r_wr;
    assign w_we        = w_set_dirty | (w_alloc & mem_ack);
    assign w_wdata     = w_alloc ? mem_rdata : r_wdata;
    assign w_install   = w_alloc & mem_ack & w_last;

    dcache_line_store #(
        .LINES(LINES),
        .WORDS(WORDS)
    ) u_store (
        .clk        (clk),
        .rst        (rst),
        .i_idx      (w_r_idx),
        .i_off      (w_off),
        .o_tag      (w_line_tag),
        .o_valid    (w_line_valid),
        .o_dirty    (w_line_dirty),
        .o_rdata    (w_line_rdata),
        .i_we       (w_we),
        .i_wdata    (w_wdata),
        .i_set_dirty(w_set_dirty),
        .i_install  (w_install),
        .i_tag      (w_r_tag)
    );

    assign done      = w_hit;
    assign cache_hit = w_hit & ~r_missed;
    assign data_out  = (w_hit & ~r_wr) ? w_line_rdata : r_dout;
    assign stall     = ~w_idle | w_accept;
    assign err       = w_illegal;
    assign mem_req   = w_wb | w_alloc;
    assign mem_we    = w_wb;
    assign mem_wdata = w_wb ? w_line_rdata : 16'h0000;

    // Victim address uses the stored tag, refill uses the requested tag
    always_comb begin
        mem_addr = 16'h0000;
        if (w_wb)
            mem_addr = {w_line_tag, w_r_idx, r_cnt, 1'b0};
        else if (w_alloc)
            mem_addr = {w_r_tag, w_r_idx, r_cnt, 1'b0};
    end

    // Request FSM with word counter driving the memory bursts
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_wr     <= 1'b0;
            r_missed <= 1'b0;
            r_cnt    <= '0;
            r_dout   <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr   <= addr[15:1];
                        r_wdata  <= data_in;
                        r_wr     <= wr;
                        r_missed <= 1'b0;
                        r_cnt    <= '0;
                        r_state  <= S_COMPARE;
                    end
                end
                S_COMPARE: begin
                    if (w_hit) begin
                        if (!r_wr)
                            r_dout <= w_line_rdata;
                        r_state <= S_IDLE;
                    end else begin
                        r_missed <= 1'b1;
                        r_cnt    <= '0;
                        r_state  <= (w_line_valid && w_line_dirty)
                                    ? S_WRITEBACK : S_ALLOCATE;
                    end
                end
                S_WRITEBACK: begin
                    if (mem_ack) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (w_last)
                            r_state <= S_ALLOCATE;
                    end
                end
                S_ALLOCATE: begin
                    if (mem_ack) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (w_last)
                            r_state <= S_COMPARE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    logic [15:0] r_hit_cnt;
    logic [15:0] r_miss_cnt;

    // Saturating first-lookup hit and miss counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (cache_hit && r_hit_cnt != 16'hFFFF)
                r_hit_cnt <= r_hit_cnt + 16'd1;
            if (w_miss && r_miss_cnt != 16'hFFFF)
                r_miss_cnt <= r_miss_cnt + 16'd1;
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
`else
    assign hit_cnt  = 16'h0000;
    assign miss_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed self-checking bench for dcache_ctrl.
// Expected counter values follow DCACHE_STATS_EN.
module tb_dcache_ctrl;

    logic        clk;
    logic        rst;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic        rd;
    logic        wr;
    logic [15:0] data_out;
    logic        done;
    logic        stall;
    logic        cache_hit;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;

    int n_checks = 0;
    int n_errors = 0;

`ifdef DCACHE_STATS_EN
    localparam logic [15:0] EXP_HITS   = 16'd2;
    localparam logic [15:0] EXP_MISSES = 16'd2;
    localparam logic [15:0] EXP_MISS_R = 16'd1;
`else
    localparam logic [15:0] EXP_HITS   = 16'd0;
    localparam logic [15:0] EXP_MISSES = 16'd0;
    localparam logic [15:0] EXP_MISS_R = 16'd0;
`endif

    dcache_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .data_in  (data_in),
        .rd       (rd),
        .wr       (wr),
        .data_out (data_out),
        .done     (done),
        .stall    (stall),
        .cache_hit(cache_hit),
        .err      (err),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a request at a falling edge; accept cycle must stall
    task automatic issue(input logic r, input logic w,
                         input logic [15:0] a, input logic [15:0] d,
                         input string tag);
        @(negedge clk);
        rd = r;
        wr = w;
        addr = a;
        data_in = d;
        #1;
        check({tag, "_stall_accept"}, 16'(stall), 16'd1);
        @(negedge clk);
        rd = 1'b0;
        wr = 1'b0;
    endtask

    // Wait (bounded) for a memory word, check it, then acknowledge it
    task automatic serve(input string tag, input logic we,
                         input logic [15:0] a, input logic [15:0] wd,
                         input logic [15:0] rdat, input int wait_cyc);
        int n;
        n = 0;
        while (!mem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_req"}, 16'(mem_req), 16'd1);
        check({tag, "_we"}, 16'(mem_we), 16'(we));
        check({tag, "_addr"}, mem_addr, a);
        if (we)
            check({tag, "_wdata"}, mem_wdata, wd);
        for (int i = 0; i < wait_cyc; i++) begin
            @(negedge clk);
            check({tag, "_addr_hold"}, mem_addr, a);
        end
        mem_rdata = rdat;
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        mem_rdata = 16'h0000;
    endtask

    initial begin
        rst = 1'b0;
        addr = 16'h0000;
        data_in = 16'h0000;
        rd = 1'b0;
        wr = 1'b0;
        mem_rdata = 16'h0000;
        mem_ack = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_stall", 16'(stall), 16'd0);
        check("rst_done", 16'(done), 16'd0);
        check("rst_req", 16'(mem_req), 16'd0);
        check("rst_maddr", mem_addr, 16'h0000);
        check("rst_dout", data_out, 16'h0000);
        check("rst_hits", hit_cnt, 16'h0000);
        check("rst_miss", miss_cnt, 16'h0000);
        rst = 1'b1;

        // Cold miss on 0x0040, clean line: refill only
        issue(1'b1, 1'b0, 16'h0040, 16'h0000, "ld40");
        check("ld40_cmp_done", 16'(done), 16'd0);
        serve("ld40_r0", 1'b0, 16'h0040, 16'h0, 16'h1111, 0);
        serve("ld40_r1", 1'b0, 16'h0042, 16'h0, 16'h2222, 2);
        serve("ld40_r2", 1'b0, 16'h0044, 16'h0, 16'h3333, 0);
        serve("ld40_r3", 1'b0, 16'h0046, 16'h0, 16'h4444, 1);
        check("ld40_done", 16'(done), 16'd1);
        check("ld40_dout", data_out, 16'h1111);
        check("ld40_hit", 16'(cache_hit), 16'd0);
        check("ld40_req_off", 16'(mem_req), 16'd0);
        @(negedge clk);
        check("ld40_unstall", 16'(stall), 16'd0);
        check("ld40_hold", data_out, 16'h1111);

        // Load hit at 0x0042
        issue(1'b1, 1'b0, 16'h0042, 16'h0000, "ld42");
        check("ld42_done", 16'(done), 16'd1);
        check("ld42_dout", data_out, 16'h2222);
        check("ld42_hit", 16'(cache_hit), 16'd1);
        check("ld42_req", 16'(mem_req), 16'd0);
        check("ld42_stall", 16'(stall), 16'd1);
        @(negedge clk);
        check("ld42_unstall", 16'(stall), 16'd0);
        check("ld42_pulse", 16'(done), 16'd0);

        // Store hit at 0x0044 dirties the line
        issue(1'b0, 1'b1, 16'h0044, 16'hBEEF, "st44");
        check("st44_done", 16'(done), 16'd1);
        check("st44_hit", 16'(cache_hit), 16'd1);
        @(negedge clk);
        check("st44_unstall", 16'(stall), 16'd0);

        // Conflict miss at 0x0444: writeback victim then refill
        issue(1'b1, 1'b0, 16'h0444, 16'h0000, "ld444");
        check("ld444_cmp_done", 16'(done), 16'd0);
        serve("wb0", 1'b1, 16'h0040, 16'h1111, 16'h0, 0);
        serve("wb1", 1'b1, 16'h0042, 16'h2222, 16'h0, 1);
        serve("wb2", 1'b1, 16'h0044, 16'hBEEF, 16'h0, 0);
        serve("wb3", 1'b1, 16'h0046, 16'h4444, 16'h0, 0);
        serve("rf0", 1'b0, 16'h0440, 16'h0, 16'h5555, 0);
        serve("rf1", 1'b0, 16'h0442, 16'h0, 16'h6666, 0);
        serve("rf2", 1'b0, 16'h0444, 16'h0, 16'h7777, 0);
        serve("rf3", 1'b0, 16'h0446, 16'h0, 16'h8888, 0);
        check("ld444_done", 16'(done), 16'd1);
        check("ld444_dout", data_out, 16'h7777);
        check("ld444_hit", 16'(cache_hit), 16'd0);
        @(negedge clk);
        check("stat_hits", hit_cnt, EXP_HITS);
        check("stat_miss", miss_cnt, EXP_MISSES);

        // Illegal requests: rd&wr, then odd address
        rd = 1'b1;
        wr = 1'b1;
        addr = 16'h0040;
        #1;
        check("ill_rw_err", 16'(err), 16'd1);
        check("ill_rw_stall", 16'(stall), 16'd0);
        @(negedge clk);
        rd = 1'b0;
        wr = 1'b0;
        #1;
        check("ill_rw_pulse", 16'(err), 16'd0);
        check("ill_rw_req", 16'(mem_req), 16'd0);
        @(negedge clk);
        rd = 1'b1;
        addr = 16'h0041;
        #1;
        check("ill_odd_err", 16'(err), 16'd1);
        check("ill_odd_stall", 16'(stall), 16'd0);
        @(negedge clk);
        rd = 1'b0;
        #1;
        check("ill_odd_pulse", 16'(err), 16'd0);
        check("ill_odd_done", 16'(done), 16'd0);
        check("ill_odd_req", 16'(mem_req), 16'd0);

        // Refilled line still hits
        issue(1'b1, 1'b0, 16'h0446, 16'h0000, "ld446");
        check("ld446_done", 16'(done), 16'd1);
        check("ld446_dout", data_out, 16'h8888);
        check("ld446_hit", 16'(cache_hit), 16'd1);

        // Reset during the second refill word
        issue(1'b1, 1'b0, 16'h0840, 16'h0000, "ld840");
        serve("rr0", 1'b0, 16'h0840, 16'h0, 16'h9999, 0);
        check("rr1_req", 16'(mem_req), 16'd1);
        check("rr1_addr", mem_addr, 16'h0842);
        rst = 1'b0;
        #1;
        check("rr_req_drop", 16'(mem_req), 16'd0);
        check("rr_stall", 16'(stall), 16'd0);
        check("rr_maddr", mem_addr, 16'h0000);
        @(negedge clk);
        rst = 1'b1;

        // After reset 0x0040 misses again
        issue(1'b1, 1'b0, 16'h0040, 16'h0000, "re40");
        check("re40_cmp_done", 16'(done), 16'd0);
        serve("re40_r0", 1'b0, 16'h0040, 16'h0, 16'hA0A0, 0);
        serve("re40_r1", 1'b0, 16'h0042, 16'h0, 16'hA1A1, 0);
        serve("re40_r2", 1'b0, 16'h0044, 16'h0, 16'hA2A2, 0);
        serve("re40_r3", 1'b0, 16'h0046, 16'h0, 16'hA3A3, 0);
        check("re40_done", 16'(done), 16'd1);
        check("re40_dout", data_out, 16'hA0A0);
        check("re40_hit", 16'(cache_hit), 16'd0);
        @(negedge clk);
        check("re40_hits", hit_cnt, 16'h0000);
        check("re40_miss", miss_cnt, EXP_MISS_R);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
